// File: rtl/ram_pkg.sv
// Shared definitions for the ram_dp_be memory macro.
//   ram_state_e  : init/run sequencing state
//   bytes_of()   : number of byte lanes in a data word
//   calc_parity(): even-parity bit for one byte
package ram_pkg;

  typedef enum logic [0:0] {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_e;

  function automatic int unsigned bytes_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic calc_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset initialisation sequencer for ram_dp_be.
// Sweeps addresses 0..LENGTH-1, one per cycle, requesting an all-zero write,
// then enters RUN and raises ready. A reset at any time restarts the sweep.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   init_we   : clear-write request for init_addr (high throughout INIT)
//   init_addr : address being cleared this cycle
//   ready     : high in RUN
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LENGTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LENGTH - 1);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RAM_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RAM_INIT: begin
        if (cnt_q == LastAddr) begin
          state_d = RAM_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RAM_RUN: begin
        state_d = RAM_RUN;
      end
    endcase
  end

  assign init_we   = (state_q == RAM_INIT);
  assign init_addr = cnt_q;
  assign ready     = (state_q == RAM_RUN);

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-enabled write port and registered read port.
// After reset the whole array is cleared by ram_init_seq before ready rises.
// Same-address read/write in one cycle is write-first per byte lane.
// Addresses >= LENGTH drop writes and read back zero.
// Optional feature macro: RAM_PARITY_EN adds one even-parity bit per byte and
// the rd_perr output.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   ready             : initialisation complete; gate wr_en/rd_en with it
//   wr_en/addr/data/be: write request, byte enable bit i covers byte i
//   rd_en/addr        : read request
//   rd_data, rd_valid : registered read result and its update strobe
//   rd_perr           : parity mismatch on rd_data (RAM_PARITY_EN only)
// DATA_WIDTH must be a multiple of 8; 1 <= LENGTH <= 2**ADDR_WIDTH.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH     = 1 << ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            ready,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [bytes_of(DATA_WIDTH)-1:0] wr_be,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]           rd_data,
`ifdef RAM_PARITY_EN
  output logic                            rd_perr,
`endif
  output logic                            rd_valid
);

  localparam int unsigned         NumBytes = bytes_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] LenW     = (ADDR_WIDTH + 1)'(LENGTH);

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LENGTH     (LENGTH)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  logic [DATA_WIDTH-1:0] mem [LENGTH];
`ifdef RAM_PARITY_EN
  logic [NumBytes-1:0]   par [LENGTH];
`endif

  logic wr_in_range, rd_in_range;
  logic wr_hit, rd_hit, same_addr;

  assign wr_in_range = ({1'b0, wr_addr} < LenW);
  assign rd_in_range = ({1'b0, rd_addr} < LenW);
  // User requests are only honoured once the clear sweep has finished.
  assign wr_hit      = ready & wr_en & wr_in_range;
  assign rd_hit      = ready & rd_en;
  assign same_addr   = (wr_addr == rd_addr);

  // Array write: the init sweep owns the port during INIT, the user after.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= '0;
`ifdef RAM_PARITY_EN
      par[init_addr] <= '0;
`endif
    end else if (wr_hit) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef RAM_PARITY_EN
          par[wr_addr][i] <= calc_parity(wr_data[8*i +: 8]);
`endif
        end
      end
    end
  end

  // Read word assembly with per-byte write-first forwarding.
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    if (rd_in_range) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_hit && same_addr && wr_be[i]) begin
          // Forwarded bytes carry freshly computed parity, so never flag.
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end else begin
          rd_word[8*i +: 8] = mem[rd_addr][8*i +: 8];
`ifdef RAM_PARITY_EN
          if (par[rd_addr][i] != calc_parity(mem[rd_addr][8*i +: 8])) begin
            rd_err = 1'b1;
          end
`endif
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  rd_perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_hit;
      if (rd_hit) begin
        rd_data_q <= rd_word;
        rd_perr_q <= rd_err;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`ifdef RAM_PARITY_EN
  assign rd_perr  = rd_perr_q;
`else
  // Without parity rd_err is constant zero and this register is unused.
  logic unused_perr;
  assign unused_perr = rd_perr_q;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed self-checking bench for ram_dp_be.
// dut16: ADDR_WIDTH=4, LENGTH=16 (power of two); dut10: ADDR_WIDTH=4, LENGTH=10.
module tb_ram_dp_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // dut16 signals
  logic        rst_a = 1'b1;
  logic        ready_a;
  logic        wr_en_a = 1'b0;
  logic [3:0]  wr_addr_a = '0;
  logic [31:0] wr_data_a = '0;
  logic [3:0]  wr_be_a = '0;
  logic        rd_en_a = 1'b0;
  logic [3:0]  rd_addr_a = '0;
  logic [31:0] rd_data_a;
  logic        rd_valid_a;
  logic        rd_perr_a;

  // dut10 signals
  logic        rst_b = 1'b1;
  logic        ready_b;
  logic        wr_en_b = 1'b0;
  logic [3:0]  wr_addr_b = '0;
  logic [31:0] wr_data_b = '0;
  logic [3:0]  wr_be_b = '0;
  logic        rd_en_b = 1'b0;
  logic [3:0]  rd_addr_b = '0;
  logic [31:0] rd_data_b;
  logic        rd_valid_b;
  logic        rd_perr_b;

`ifndef RAM_PARITY_EN
  assign rd_perr_a = 1'b0;
  assign rd_perr_b = 1'b0;
`endif

  ram_dp_be #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32),
    .LENGTH     (16)
  ) dut16 (
    .clk      (clk),
    .rst      (rst_a),
    .ready    (ready_a),
    .wr_en    (wr_en_a),
    .wr_addr  (wr_addr_a),
    .wr_data  (wr_data_a),
    .wr_be    (wr_be_a),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
`ifdef RAM_PARITY_EN
    .rd_perr  (rd_perr_a),
`endif
    .rd_valid (rd_valid_a)
  );

  ram_dp_be #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32),
    .LENGTH     (10)
  ) dut10 (
    .clk      (clk),
    .rst      (rst_b),
    .ready    (ready_b),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_data  (wr_data_b),
    .wr_be    (wr_be_b),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
`ifdef RAM_PARITY_EN
    .rd_perr  (rd_perr_b),
`endif
    .rd_valid (rd_valid_b)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d; wr_be_a = be;
    tick();
    wr_en_a = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] a);
    rd_en_a = 1'b1; rd_addr_a = a;
    tick();
    rd_en_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready_a); end
    n_cmp++; if (rd_data_a !== 32'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data_a); end
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_a); end
    for (int i = 1; i < 16; i++) begin
      tick();
      n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL init_ready cyc %0d got %b want 0", i, ready_a); end
    end
    tick();
    n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL init_done got %b want 1", ready_a); end
  endtask

  task automatic test_clear_readback();
    // Back-to-back reads, one per cycle.
    for (int a = 0; a < 16; a++) begin
      rd_en_a = 1'b1; rd_addr_a = 4'(a);
      tick();
      n_cmp++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
        n_err++; $display("FAIL clear_read addr %0d got %h/%b want 00000000/1", a, rd_data_a, rd_valid_a);
      end
    end
    rd_en_a = 1'b0;
    tick();
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", rd_valid_a); end
  endtask

  task automatic test_byte_enable();
    write_a(4'd3, 32'hDEADBEEF, 4'b1111);
    write_a(4'd3, 32'h000000AA, 4'b0001);
    write_a(4'd4, 32'h12345678, 4'b0000);
    read_a(4'd3);
    n_cmp++; if (rd_data_a !== 32'hDEADBEAA || rd_valid_a !== 1'b1) begin
      n_err++; $display("FAIL byte_merge got %h/%b want deadbeaa/1", rd_data_a, rd_valid_a);
    end
    tick();
    n_cmp++; if (rd_data_a !== 32'hDEADBEAA || rd_valid_a !== 1'b0) begin
      n_err++; $display("FAIL hold got %h/%b want deadbeaa/0", rd_data_a, rd_valid_a);
    end
    read_a(4'd4);
    n_cmp++; if (rd_data_a !== 32'h0) begin n_err++; $display("FAIL be_zero got %h want 0", rd_data_a); end
  endtask

  task automatic test_collision();
    write_a(4'd5, 32'hAABBCCDD, 4'b1111);
    wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 32'h11223344; wr_be_a = 4'b1100;
    rd_en_a = 1'b1; rd_addr_a = 4'd5;
    tick();
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    n_cmp++; if (rd_data_a !== 32'h1122CCDD || rd_valid_a !== 1'b1) begin
      n_err++; $display("FAIL collision got %h/%b want 1122ccdd/1", rd_data_a, rd_valid_a);
    end
    read_a(4'd5);
    n_cmp++; if (rd_data_a !== 32'h1122CCDD) begin n_err++; $display("FAIL after_collision got %h want 1122ccdd", rd_data_a); end
    read_a(4'd3);
    n_cmp++; if (rd_data_a !== 32'hDEADBEAA) begin n_err++; $display("FAIL neighbour got %h want deadbeaa", rd_data_a); end
  endtask

  task automatic test_reset_restart();
    write_a(4'd9, 32'h00000055, 4'b1111);
    read_a(4'd9);
    n_cmp++; if (rd_data_a !== 32'h55) begin n_err++; $display("FAIL pre_restart got %h want 00000055", rd_data_a); end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_cmp++; if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b0 || ready_a !== 1'b0) begin
      n_err++; $display("FAIL rerst_state got %h/%b/%b want 0/0/0", rd_data_a, rd_valid_a, ready_a);
    end
    // Seven clear writes (addresses 0..6), then reset again mid-sweep.
    for (int i = 0; i < 7; i++) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL restart_ready cyc %0d got %b want 0", i, ready_a); end
    end
    tick();
    n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL restart_done got %b want 1", ready_a); end
    read_a(4'd9);
    n_cmp++; if (rd_data_a !== 32'h0) begin n_err++; $display("FAIL restart_clear got %h want 0", rd_data_a); end
  endtask

  task automatic test_out_of_range();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    rd_en_b = 1'b1; rd_addr_b = 4'd1;
    for (int i = 1; i < 10; i++) begin
      tick();
      n_cmp++; if (ready_b !== 1'b0 || rd_valid_b !== 1'b0) begin
        n_err++; $display("FAIL init10 cyc %0d got ready %b valid %b want 0/0", i, ready_b, rd_valid_b);
      end
    end
    tick();
    rd_en_b = 1'b0;
    n_cmp++; if (ready_b !== 1'b1 || rd_valid_b !== 1'b0) begin
      n_err++; $display("FAIL init10_done got ready %b valid %b want 1/0", ready_b, rd_valid_b);
    end
    wr_en_b = 1'b1; wr_addr_b = 4'd12; wr_data_b = 32'hCAFEF00D; wr_be_b = 4'b1111;
    tick();
    wr_addr_b = 4'd9; wr_data_b = 32'h12345678;
    tick();
    // Out-of-range write with same-address read: nothing may be forwarded.
    wr_addr_b = 4'd12; wr_data_b = 32'hFFFFFFFF;
    rd_en_b = 1'b1; rd_addr_b = 4'd12;
    tick();
    wr_en_b = 1'b0;
    n_cmp++; if (rd_data_b !== 32'h0 || rd_valid_b !== 1'b1) begin
      n_err++; $display("FAIL oor_read got %h/%b want 00000000/1", rd_data_b, rd_valid_b);
    end
    rd_addr_b = 4'd9;
    tick();
    n_cmp++; if (rd_data_b !== 32'h12345678) begin n_err++; $display("FAIL last_addr got %h want 12345678", rd_data_b); end
    rd_addr_b = 4'd2;
    tick();
    n_cmp++; if (rd_data_b !== 32'h0) begin n_err++; $display("FAIL no_alias got %h want 0", rd_data_b); end
    rd_addr_b = 4'd12;
    tick();
    rd_en_b = 1'b0;
    n_cmp++; if (rd_data_b !== 32'h0 || rd_valid_b !== 1'b1) begin
      n_err++; $display("FAIL oor_reread got %h/%b want 00000000/1", rd_data_b, rd_valid_b);
    end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    write_a(4'd2, 32'h0F0F0F0F, 4'b1111);
    write_a(4'd3, 32'h01020304, 4'b1111);
    dut16.mem[2][4] = ~dut16.mem[2][4];
    read_a(4'd2);
    n_cmp++; if (rd_perr_a !== 1'b1 || rd_valid_a !== 1'b1 || rd_data_a !== 32'h0F0F0F1F) begin
      n_err++; $display("FAIL perr_flip got %b/%b/%h want 1/1/0f0f0f1f", rd_perr_a, rd_valid_a, rd_data_a);
    end
    read_a(4'd3);
    n_cmp++; if (rd_perr_a !== 1'b0) begin n_err++; $display("FAIL perr_intact got %b want 0", rd_perr_a); end
    // Rewriting the corrupt byte while reading it forwards fresh parity.
    wr_en_a = 1'b1; wr_addr_a = 4'd2; wr_data_a = 32'h00000077; wr_be_a = 4'b0001;
    rd_en_a = 1'b1; rd_addr_a = 4'd2;
    tick();
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    n_cmp++; if (rd_perr_a !== 1'b0 || rd_data_a !== 32'h0F0F0F77) begin
      n_err++; $display("FAIL perr_fwd got %b/%h want 0/0f0f0f77", rd_perr_a, rd_data_a);
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_clear_readback();
    test_byte_enable();
    test_collision();
    test_reset_restart();
    test_out_of_range();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised simple dual-port RAM: one write port with byte enables, one registered read port with a valid strobe, and a self-clearing initialisation sequence after reset. It is the next-generation memory macro for the datapath and replaces single-port, tristate-bus RAM wherever read and write must proceed in the same cycle. All ports are point-to-point; there are no bidirectional buses.

## Interface
Parameters:
- ADDR_WIDTH, 12, address bits.
- DATA_WIDTH, 32, word width. Must be a multiple of 8.
- LENGTH, 1<<ADDR_WIDTH, number of words. Must satisfy 1 ≤ LENGTH ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once initialisation clear is complete.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_valid  out  1  rd_data was updated this cycle.
- rd_perr  out  1  parity error on the current rd_data. Present only with RAM_PARITY_EN.

## Operation
- FSM states:
  - INIT: a counter sweeps addresses 0..LENGTH-1 and writes all-zero data, including zero parity, one word per cycle.
  - RUN: normal operation.
- Transitions:
  - rst → INIT with counter = 0.
  - INIT with counter == LENGTH-1 → RUN.
  - rst asserted in any state, including mid-sweep, restarts INIT from address 0.
- In INIT, wr_en and rd_en are ignored. rd_valid stays 0.
- Write in RUN: for each i with wr_be[i] = 1, byte i of mem[wr_addr] takes wr_data byte i. Other bytes are unchanged. wr_be = 0 is a no-op.
- Read in RUN: rd_en = 1 → rd_data = mem[rd_addr] and rd_valid = 1 on the next edge. With rd_en = 0, rd_data holds its value and rd_valid = 0.
- Collision: wr_en and rd_en in the same cycle with wr_addr == rd_addr gives write-first behaviour. rd_data returns the new bytes where wr_be is set and the old bytes elsewhere.
- Out-of-range addresses (addr ≥ LENGTH) occur only when LENGTH is not a power of two:
  - Write: dropped.
  - Read: returns all-zero data with rd_valid = 1 (and rd_perr = 0).

## Timing
- Reset values: ready = 0, rd_data = 0, rd_valid = 0, rd_perr = 0.
- INIT lasts exactly LENGTH cycles after the rst-deasserted edge. ready rises on the edge after the final clear write.
- Read latency is 1 cycle from rd_en sampled to rd_valid/rd_data. One read per cycle is sustained.
- Write latency: data is visible to a read issued in the same cycle (via forwarding) and to any later read.
- No backpressure. The requester must gate wr_en and rd_en with ready.

## Configuration
- RAM_PARITY_EN defined:
  - One even-parity bit is stored per byte and written alongside each enabled byte.
  - On read, parity is recomputed. rd_perr = 1 with rd_valid if any byte mismatches.
  - Forwarded bytes use the freshly computed parity.
- RAM_PARITY_EN undefined: no parity storage and no rd_perr port. All other behaviour is identical.

## Structure
- Shared package ram_pkg holds:
  - the state enum (RAM_INIT, RAM_RUN);
  - the function bytes_of(DATA_WIDTH);
  - the function calc_parity(byte).
- Sub-module ram_init_seq contains the INIT/RUN FSM and the sweep counter. It outputs init_we, init_addr and ready.
- The top level muxes init_* with the user write port and holds the array and read/forwarding logic.

## Test plan
- Reset with LENGTH = 16 → ready stays 0 for 16 cycles, then goes 1. Reading all 16 addresses returns 0x00000000.
- Write 0xDEADBEEF to address 3 with be = 4'b1111, then write 0x000000AA with be = 4'b0001 → reading address 3 gives 0xDEADBEAA after 1 cycle, with rd_valid = 1.
- Same cycle: write 0x11223344 with be = 4'b1100 to address 5 (previously 0xAABBCCDD) and read address 5 → rd_data = 0x1122CCDD.
- Assert rst at sweep address 7 → ready stays 0 and the sweep restarts at 0. ready rises LENGTH cycles after rst deasserts.
- LENGTH = 10, ADDR_WIDTH = 4: write to address 12 is dropped; reading address 12 gives 0 with rd_valid = 1. rd_en issued during INIT produces no rd_valid.
- With RAM_PARITY_EN: force-flip one stored bit of address 2 → the read of address 2 gives rd_perr = 1. Reading an intact address gives rd_perr = 0.
